// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared constants and types for the 4x4 keypad reader.
//   KP_ROWS/KP_COLS : matrix geometry
//   KP_ROW_W        : row index width
//   KP_CODE_W       : key code width (row*4+col)
//   kp_state_t      : key state machine encoding
package keypad_scan_pkg;
   localparam int KP_ROWS   = 4;
   localparam int KP_COLS   = 4;
   localparam int KP_ROW_W  = 2;
   localparam int KP_COL_W  = 2;
   localparam int KP_CODE_W = 4;

   typedef enum logic {
      KP_IDLE    = 1'b0,
      KP_PRESSED = 1'b1
   } kp_state_t;
endpackage

// File: rtl/kp_row_scan.sv
// kp_row_scan: row slot timing for the keypad matrix.
//   clk, rst_n     : clock, async active-low reset
//   o_row          : active-low one-hot row drive, row 0 after reset
//   o_row_idx      : index of the row currently driven
//   o_sample       : high on the last cycle of each row slot (column sample point)
//   o_frame_end    : o_sample on row 3, the last sample of a scan frame
module kp_row_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [KP_ROWS-1:0]  o_row,
   output logic [KP_ROW_W-1:0] o_row_idx,
   output logic                o_sample,
   output logic                o_frame_end
);
   localparam int SLOT_W = $clog2(SCAN_DIV);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

   logic [SLOT_W-1:0]   r_slot;
   logic [KP_ROW_W-1:0] r_row_idx;
   logic [KP_ROWS-1:0]  r_row;
   logic                w_wrap;

   assign w_wrap = (r_slot == SLOT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot    <= '0;
         r_row_idx <= '0;
         r_row     <= 4'b1110;
      end else if (w_wrap) begin
         r_slot    <= '0;
         r_row_idx <= r_row_idx + 1'b1;
         // rotate the single low bit to the next row
         r_row     <= {r_row[KP_ROWS-2:0], r_row[KP_ROWS-1]};
      end else begin
         r_slot    <= r_slot + 1'b1;
      end
   end

   // sampling on the wrap cycle gives the columns SCAN_DIV-1 cycles to settle
   assign o_row       = r_row;
   assign o_row_idx   = r_row_idx;
   assign o_sample    = w_wrap;
   assign o_frame_end = w_wrap && (r_row_idx == KP_ROW_W'(KP_ROWS - 1));
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scanned 4x4 matrix keypad reader with frame debounce.
//   clk, rst_n     : clock, async active-low reset
//   o_row          : active-low one-hot row drive
//   i_col          : active-low column sense, asynchronous to clk
//   o_key_code     : accepted key, row*4+col (holds after release)
//   o_key_valid    : one-clk pulse when a new key is accepted
//   o_key_pressed  : an accepted key is currently held
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [KP_ROWS-1:0]   o_row,
   input  logic [KP_COLS-1:0]   i_col,
   output logic [KP_CODE_W-1:0] o_key_code,
   output logic                 o_key_valid,
   output logic                 o_key_pressed
);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

   logic [KP_ROW_W-1:0]  w_row_idx;
   logic                 w_sample;
   logic                 w_frame_end;

   logic [KP_COLS-1:0]   r_col_s1, r_col_s2;
   logic                 r_cap_hit;
   logic [KP_CODE_W-1:0] r_cap_code;
   logic                 r_prev_hit;
   logic [KP_CODE_W-1:0] r_prev_code;
   logic [CNT_W-1:0]     r_cnt;
   kp_state_t            r_state;
   logic [KP_CODE_W-1:0] r_key_code;
   logic                 r_key_valid;
   logic                 r_key_pressed;

   logic [KP_COLS-1:0]   w_col_n;
   logic                 w_row_hit;
   logic [KP_COL_W-1:0]  w_row_col;
   logic [KP_CODE_W-1:0] w_row_code;
   logic                 w_fr_hit;
   logic [KP_CODE_W-1:0] w_fr_code;
   logic                 w_same;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 w_stable;

   kp_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .o_row       (o_row),
      .o_row_idx   (w_row_idx),
      .o_sample    (w_sample),
      .o_frame_end (w_frame_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_s1 <= '1;
         r_col_s2 <= '1;
      end else begin
         r_col_s1 <= i_col;
         r_col_s2 <= r_col_s1;
      end
   end

   // lowest pressed column in the current row wins
   assign w_col_n   = ~r_col_s2;
   assign w_row_hit = |w_col_n;
   always_comb begin
      w_row_col = '0;
      for (int c = KP_COLS - 1; c >= 0; c--)
         if (w_col_n[c]) w_row_col = KP_COL_W'(c);
   end
   assign w_row_code = {w_row_idx, w_row_col};

   // frame result folds in the row-3 sample; code is zeroed on no-hit so
   // all no-hit frames compare equal
   assign w_fr_hit   = r_cap_hit | w_row_hit;
   assign w_fr_code  = r_cap_hit ? r_cap_code : (w_row_hit ? w_row_code : '0);
   assign w_same     = (w_fr_hit == r_prev_hit) && (w_fr_code == r_prev_code);
   assign w_cnt_next = !w_same ? CNT_W'(1) :
                       (r_cnt == DB_MAX) ? DB_MAX : r_cnt + CNT_W'(1);
   assign w_stable   = (w_cnt_next == DB_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap_hit     <= 1'b0;
         r_cap_code    <= '0;
         r_prev_hit    <= 1'b0;
         r_prev_code   <= '0;
         r_cnt         <= '0;
         r_state       <= KP_IDLE;
         r_key_code    <= '0;
         r_key_valid   <= 1'b0;
         r_key_pressed <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_frame_end) begin
            r_cap_hit   <= 1'b0;
            r_cap_code  <= '0;
            r_prev_hit  <= w_fr_hit;
            r_prev_code <= w_fr_code;
            r_cnt       <= w_cnt_next;
            case (r_state)
               KP_IDLE: begin
                  if (w_fr_hit && w_stable) begin
                     r_state       <= KP_PRESSED;
                     r_key_code    <= w_fr_code;
                     r_key_pressed <= 1'b1;
                     r_key_valid   <= 1'b1;
                  end
               end
               KP_PRESSED: begin
                  if (w_stable) begin
                     if (!w_fr_hit) begin
                        r_state       <= KP_IDLE;
                        r_key_pressed <= 1'b0;
                     end else if (w_fr_code != r_key_code) begin
                        // key change without release counts as a new key
                        r_key_code  <= w_fr_code;
                        r_key_valid <= 1'b1;
                     end
                  end
               end
               default: r_state <= KP_IDLE;
            endcase
         end else if (w_sample && !r_cap_hit && w_row_hit) begin
            r_cap_hit  <= 1'b1;
            r_cap_code <= w_row_code;
         end
      end
   end

   assign o_key_code    = r_key_code;
   assign o_key_valid   = r_key_valid;
   assign o_key_pressed = r_key_pressed;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=8,
// DEBOUNCE_FRAMES=3. After reset release at a negedge, frame f ends at
// posedge 32*f; checks sample on the negedge following each posedge.
module tb_keypad_scan;
   localparam int SD = 8;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] o_row;
   logic [3:0] i_col;
   logic [3:0] o_key_code;
   logic       o_key_valid;
   logic       o_key_pressed;
   logic [15:0] keys = 16'h0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // keypad model: column c pulled low while row r is driven and key held
   always_comb begin
      i_col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !o_row[r]) i_col[c] = 1'b0;
   end

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_row         (o_row),
      .i_col         (i_col),
      .o_key_code    (o_key_code),
      .o_key_valid   (o_key_valid),
      .o_key_pressed (o_key_pressed)
   );

   task automatic start(input logic [15:0] k);
      rst_n = 1'b0;
      keys  = k;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [3:0] er;
      rst_n = 1'b0;
      keys  = 16'h0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({o_row, o_key_code, o_key_valid, o_key_pressed} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_vals got row=%b code=%0d v=%b p=%b want row=1110 code=0 v=0 p=0",
                  o_row, o_key_code, o_key_valid, o_key_pressed);
      end
      rst_n = 1'b1;
      for (int m = 1; m <= 64; m++) begin
         @(negedge clk);
         er = ~(4'b0001 << ((m / SD) % 4));
         n_chk++;
         if ({o_row, o_key_code, o_key_valid, o_key_pressed} !== {er, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL row_walk m=%0d got row=%b code=%0d v=%b p=%b want row=%b code=0 v=0 p=0",
                     m, o_row, o_key_code, o_key_valid, o_key_pressed, er);
         end
      end
   endtask

   task automatic test_hold;
      logic ev, ep;
      logic [3:0] ec;
      start(16'h0001 << 9);  // key (2,1)
      for (int m = 1; m <= 96 + 320; m++) begin
         @(negedge clk);
         ev = (m == 96);
         ep = (m >= 96);
         ec = (m >= 96) ? 4'd9 : 4'd0;
         n_chk++;
         if ({o_key_valid, o_key_pressed, o_key_code} !== {ev, ep, ec}) begin
            n_fail++;
            $display("FAIL hold m=%0d got v=%b p=%b code=%0d want v=%b p=%b code=%0d",
                     m, o_key_valid, o_key_pressed, o_key_code, ev, ep, ec);
         end
      end
   endtask

   task automatic test_bounce;
      start(16'h0001 << 7);  // key (1,3), present frames 1-2, absent frame 3, ...
      for (int m = 1; m <= 12 * 32; m++) begin
         @(negedge clk);
         n_chk++;
         if ({o_key_valid, o_key_pressed, o_key_code} !== {1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL bounce m=%0d got v=%b p=%b code=%0d want v=0 p=0 code=0",
                     m, o_key_valid, o_key_pressed, o_key_code);
         end
         if (m % 96 == 64) keys = 16'h0;
         else if (m % 96 == 0) keys = 16'h0001 << 7;
      end
   endtask

   task automatic test_change;
      logic ev, ep;
      logic [3:0] ec;
      start(16'h0001);  // key (0,0)
      for (int m = 1; m <= 320; m++) begin
         @(negedge clk);
         ev = (m == 96) || (m == 192);
         ep = (m >= 96) && (m < 288);
         ec = (m >= 192) ? 4'd15 : 4'd0;
         n_chk++;
         if ({o_key_valid, o_key_pressed, o_key_code} !== {ev, ep, ec}) begin
            n_fail++;
            $display("FAIL change m=%0d got v=%b p=%b code=%0d want v=%b p=%b code=%0d",
                     m, o_key_valid, o_key_pressed, o_key_code, ev, ep, ec);
         end
         if (m == 96) keys = 16'h8000;       // switch to (3,3)
         else if (m == 192) keys = 16'h0000; // release
      end
   endtask

   task automatic test_multi;
      logic ev, ep;
      logic [3:0] ec;
      start((16'h0001 << 6) | (16'h0001 << 12));  // (1,2) and (3,0)
      for (int m = 1; m <= 128; m++) begin
         @(negedge clk);
         ev = (m == 96);
         ep = (m >= 96);
         ec = (m >= 96) ? 4'd6 : 4'd0;
         n_chk++;
         if ({o_key_valid, o_key_pressed, o_key_code} !== {ev, ep, ec}) begin
            n_fail++;
            $display("FAIL multi m=%0d got v=%b p=%b code=%0d want v=%b p=%b code=%0d",
                     m, o_key_valid, o_key_pressed, o_key_code, ev, ep, ec);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic ev, ep;
      logic [3:0] ec;
      start(16'h0001 << 9);  // key (2,1)
      repeat (72) @(negedge clk);  // two frames done, row 1 of frame 3
      n_chk++;
      if (o_row !== 4'b1101) begin
         n_fail++;
         $display("FAIL pre_reset_row got %b want 1101", o_row);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({o_row, o_key_code, o_key_valid, o_key_pressed} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset got row=%b code=%0d v=%b p=%b want row=1110 code=0 v=0 p=0",
                  o_row, o_key_code, o_key_valid, o_key_pressed);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int m = 1; m <= 100; m++) begin
         @(negedge clk);
         ev = (m == 96);
         ep = (m >= 96);
         ec = (m >= 96) ? 4'd9 : 4'd0;
         n_chk++;
         if ({o_key_valid, o_key_pressed, o_key_code} !== {ev, ep, ec}) begin
            n_fail++;
            $display("FAIL post_reset m=%0d got v=%b p=%b code=%0d want v=%b p=%b code=%0d",
                     m, o_key_valid, o_key_pressed, o_key_code, ev, ep, ec);
         end
      end
   endtask

   initial begin
      test_reset;
      test_hold;
      test_bounce;
      test_change;
      test_multi;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
